// File: rtl/sync_debounce_if.sv
//------------------------------------------------------------------------------
// Module      : sync_debounce_if
// Description : Signal bundle for the sync_debounce input conditioner.
//               master drives the raw level and enable, slave returns the
//               debounced level, its complement, edge strobes and BUSY.
//               D    - raw asynchronous level
//               EN   - debounce enable
//               Q/QN - debounced registered level and its complement
//               RISE - one-cycle strobe on accepted 0->1
//               FALL - one-cycle strobe on accepted 1->0
//               BUSY - synchronised level differs from Q
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface sync_debounce_if;
    logic D;
    logic EN;
    logic Q;
    logic QN;
    logic RISE;
    logic FALL;
    logic BUSY;

    modport master (
        output D,
        output EN,
        input  Q,
        input  QN,
        input  RISE,
        input  FALL,
        input  BUSY
    );

    modport slave (
        input  D,
        input  EN,
        output Q,
        output QN,
        output RISE,
        output FALL,
        output BUSY
    );
endinterface

`default_nettype wire

// File: rtl/sync_debounce.sv
//------------------------------------------------------------------------------
// Module      : sync_debounce
// Description : Synchronises an asynchronous single-bit level into the CK
//               domain and accepts a new level only after it has been seen
//               for DEBOUNCE_CYCLES consecutive enabled edges.
// Ports       : CK  - clock, rising edge
//               RN  - asynchronous active-low reset
//               bus - sync_debounce_if.slave (D, EN in; Q, QN, RISE, FALL,
//                     BUSY out)
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sync_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input  wire             CK,
    input  wire             RN,
    sync_debounce_if.slave  bus
);

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Only the next stage samples r_sync[0]; it may go metastable.
    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_q;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_s;
    logic                   w_diff;

    assign w_s    = r_sync[SYNC_STAGES-1];
    assign w_diff = w_s ^ r_q;

    // Synchroniser shifts on every edge regardless of EN.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.D};
        end
    end

    // Debounce counter, accepted level and strobes. Strobes default low so
    // they are exactly one cycle wide and clear on EN=0 edges.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            r_cnt  <= '0;
            r_q    <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (bus.EN) begin
                if (!w_diff) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_CNT_LAST) begin
                    r_cnt  <= '0;
                    r_q    <= w_s;
                    r_rise <= w_s;
                    r_fall <= ~w_s;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.Q    = r_q;
    assign bus.QN   = ~r_q;
    assign bus.RISE = r_rise;
    assign bus.FALL = r_fall;
    // Decoded from registers only; no combinational path from D.
    assign bus.BUSY = w_diff;

endmodule

`default_nettype wire
